// File: rtl/inst_fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, keeps one memory request in flight and buffers {pc, inst} pairs for IF.
// Optional macro IFQ_MISALIGN_CHECK_EN adds a sticky misaligned-redirect flag that halts fetching until reset.
module inst_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        start,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   input  logic        if_ready,
   output logic        misalign
);

   localparam int                PTR_W = $clog2(DEPTH);
   localparam int                CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);
   localparam logic [31:0]       NOP   = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      DISCARD = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [31:0]        memAddr_q, memAddr_d;
   logic [31:0]        fetchPc_q, fetchPc_d;
   logic [31:0]        pendingPc_q, pendingPc_d;
   logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0]   count_q, count_d;

   logic [31:0]        pcMem   [DEPTH];
   logic [31:0]        instMem [DEPTH];

   logic               headValid;
   logic               pop;
   logic               push;
   logic               flush;
   logic               stopNext;
   logic [31:0]        seqPc;
   logic [31:0]        discardTarget;

   assign headValid     = (count_q != '0);
   assign pop           = headValid && if_ready;
   assign push          = (state_q == REQ) && mem_ack && !redirect_valid;
   assign flush         = redirect_valid;
   assign seqPc         = memAddr_q + 32'd4;
   assign discardTarget = redirect_valid ? redirect_pc : pendingPc_q;

`ifdef IFQ_MISALIGN_CHECK_EN
   logic misalign_q;
   logic badRedirect;

   assign badRedirect = redirect_valid && (redirect_pc[1:0] != 2'b00);
   assign stopNext    = misalign_q || badRedirect;
   assign misalign    = misalign_q;

   always_ff @(posedge clk or negedge start) begin
      if (!start) begin
         misalign_q <= 1'b0;
      end else if (badRedirect) begin
         misalign_q <= 1'b1;
      end
   end
`else
   assign stopNext = 1'b0;
   assign misalign = 1'b0;
`endif

   // Occupancy bookkeeping; a flush overrides any push or pop in the same cycle.
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (flush) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
         count_d = '0;
      end else begin
         if (push) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
         end
         if (pop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
         end
         if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
         end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   // Request sequencing; new requests are gated on the post-edge occupancy so a push can never overflow.
   always_comb begin
      state_d     = state_q;
      memAddr_d   = memAddr_q;
      fetchPc_d   = fetchPc_q;
      pendingPc_d = pendingPc_q;
      case (state_q)
         IDLE: begin
            if (redirect_valid) begin
               fetchPc_d = redirect_pc;
               if (!stopNext) begin
                  state_d   = REQ;
                  memAddr_d = redirect_pc;
               end
            end else if (!stopNext && (count_d < FULL)) begin
               state_d   = REQ;
               memAddr_d = fetchPc_q;
            end
         end
         REQ: begin
            if (mem_ack) begin
               if (redirect_valid) begin
                  fetchPc_d = redirect_pc;
                  if (stopNext) begin
                     state_d = IDLE;
                  end else begin
                     memAddr_d = redirect_pc;
                  end
               end else begin
                  fetchPc_d = seqPc;
                  if (!stopNext && (count_d < FULL)) begin
                     memAddr_d = seqPc;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end else if (redirect_valid) begin
               pendingPc_d = redirect_pc;
               state_d     = DISCARD;
            end
         end
         DISCARD: begin
            if (redirect_valid) begin
               pendingPc_d = redirect_pc;
            end
            if (mem_ack) begin
               fetchPc_d = discardTarget;
               if (stopNext) begin
                  state_d = IDLE;
               end else begin
                  state_d   = REQ;
                  memAddr_d = discardTarget;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge start) begin
      if (!start) begin
         state_q     <= IDLE;
         memAddr_q   <= RESET_PC;
         fetchPc_q   <= RESET_PC;
         pendingPc_q <= RESET_PC;
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         memAddr_q   <= memAddr_d;
         fetchPc_q   <= fetchPc_d;
         pendingPc_q <= pendingPc_d;
         wrPtr_q     <= wrPtr_d;
         rdPtr_q     <= rdPtr_d;
         count_q     <= count_d;
      end
   end

   // Storage needs no reset: entries are only visible through count_q.
   always_ff @(posedge clk) begin
      if (push) begin
         pcMem[wrPtr_q]   <= memAddr_q;
         instMem[wrPtr_q] <= mem_rdata;
      end
   end

   assign mem_req  = (state_q != IDLE);
   assign mem_addr = memAddr_q;
   assign if_valid = headValid;
   assign if_pc    = headValid ? pcMem[rdPtr_q] : 32'h0000_0000;
   assign if_inst  = headValid ? instMem[rdPtr_q] : NOP;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: the bench acts as instruction memory and tracks the
// expected queue contents and outstanding request as a plain PC queue plus a few flags.
module tb_inst_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        start = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'h0;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        if_ready = 1'b0;
   logic        misalign;

   always #5 clk = ~clk;

   inst_fetch_queue #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk            (clk),
      .start          (start),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_ack        (mem_ack),
      .mem_rdata      (mem_rdata),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_inst        (if_inst),
      .if_ready       (if_ready),
      .misalign       (misalign)
   );

   int nChecks = 0;
   int nFails  = 0;

   logic [31:0] q[$];
   bit          reqOut;
   logic [31:0] reqAddr;
   logic [31:0] nextPc;
   bit          tainted;
   bit          stopped;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nFails++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      check("mem_req", 32'(mem_req), 32'(reqOut));
      if (reqOut) begin
         check("mem_addr", mem_addr, reqAddr);
      end
      check("if_valid", 32'(if_valid), 32'(q.size() != 0));
      check("if_pc", if_pc, (q.size() != 0) ? q[0] : 32'h0);
      check("if_inst", if_inst, (q.size() != 0) ? memWord(q[0]) : 32'h0000_0013);
      check("misalign", 32'(misalign), 32'(stopped));
   endtask

   // Called mid-cycle; drives one cycle of inputs, advances the model across the edge, then checks.
   task automatic applyStimulus(input bit redir, input logic [31:0] rpc, input bit ack, input bit ready);
      bit ackEff;
      bit pop;
      bit push;
      redirect_valid = redir;
      redirect_pc    = rpc;
      if_ready       = ready;
      mem_ack        = ack & mem_req;
      mem_rdata      = memWord(mem_addr);
      ackEff = ack && reqOut;
      pop    = (q.size() != 0) && ready;
      push   = ackEff && !tainted && !redir;
      if (redir) begin
         q.delete();
         nextPc = rpc;
`ifdef IFQ_MISALIGN_CHECK_EN
         if (rpc[1:0] != 2'b00) stopped = 1'b1;
`endif
      end else begin
         if (pop) void'(q.pop_front());
         if (push) begin
            q.push_back(reqAddr);
            nextPc = reqAddr + 32'd4;
         end
      end
      if (reqOut && !ackEff) begin
         if (redir) tainted = 1'b1;
      end else if (!stopped && (q.size() < DEPTH)) begin
         reqOut  = 1'b1;
         reqAddr = nextPc;
         tainted = 1'b0;
      end else begin
         reqOut = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      checkOutput();
   endtask

   task automatic doReset();
      start          = 1'b0;
      redirect_valid = 1'b0;
      mem_ack        = 1'b0;
      if_ready       = 1'b0;
      #1;
      q.delete();
      reqOut  = 1'b0;
      reqAddr = RESET_PC;
      nextPc  = RESET_PC;
      tainted = 1'b0;
      stopped = 1'b0;
      checkOutput();
      check("mem_addr_rst", mem_addr, RESET_PC);
      @(negedge clk);
      @(negedge clk);
      start = 1'b1;
   endtask

   initial begin
      @(negedge clk);
      doReset();

      $display("[TB] streaming fetch with memory acking every cycle");
      repeat (10) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

      $display("[TB] back-pressure fills the queue then releases one slot");
      repeat (8) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      repeat (6) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

      $display("[TB] redirect while a request waits for ack");
      doReset();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      check("addr_before_redirect", mem_addr, 32'h0000_0008);
      applyStimulus(1'b1, 32'h0000_0100, 1'b0, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      check("addr_held", mem_addr, 32'h0000_0008);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      check("addr_after_discard", mem_addr, 32'h0000_0100);
      repeat (4) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

      $display("[TB] redirect coinciding with ack and pop");
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'h0000_0040, 1'b1, 1'b1);
      check("queue_empty_after_redirect", 32'(if_valid), 32'd0);
      repeat (4) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

      $display("[TB] reset mid-request with entries queued");
      repeat (3) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      doReset();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      check("first_addr_after_reset", mem_addr, RESET_PC);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            doReset();
         end else begin
            applyStimulus($urandom_range(0, 15) == 0,
                          32'($urandom_range(0, 1023)) << 2,
                          $urandom_range(0, 9) < 6,
                          $urandom_range(0, 9) < 7);
         end
      end

`ifdef IFQ_MISALIGN_CHECK_EN
      $display("[TB] misaligned redirect halts fetching");
      doReset();
      repeat (3) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      applyStimulus(1'b1, 32'h0000_0102, 1'b0, 1'b1);
      check("misalign_set", 32'(misalign), 32'd1);
      repeat (6) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      check("halted_req", 32'(mem_req), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
      $finish;
   end

endmodule
